mem_port_arbiter: RTL

Two-master arbiter that sits directly downstream of `dma_engine`'s memory port and the CPU data port, merging both onto the single shared data-RAM port. It forwards one transaction at a time using the same req/ready handshake the DMA uses. It locks the grant across downstream stalls and round-robins between masters when both request. Per-master completion counters are provided for debug and performance readout.

---
 rtl/mem_port_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master (CPU / DMA) arbiter onto one shared data-RAM port with req/ready handshake,
// grant locking across RAM stalls, round-robin or fixed-CPU priority, and saturating done counters.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int XLEN     = 32,
    parameter bit CPU_PRIO = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [XLEN-1:0]   cpu_wdata,
    output logic [XLEN-1:0]   cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_mem_req,
    input  logic              dma_mem_we,
    input  logic [ADDR_W-1:0] dma_mem_addr,
    input  logic [XLEN-1:0]   dma_mem_wdata,
    output logic [XLEN-1:0]   dma_mem_rdata,
    output logic              dma_mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  cpu_done_cnt,
    output logic [CNT_W-1:0]  dma_done_cnt
);
    typedef enum logic {IDLE, LOCKED} state_t;
    typedef enum logic {SEL_CPU, SEL_DMA} sel_t;

    state_t state;
    sel_t   lock_owner;
    sel_t   last_served;
    sel_t   owner;
    logic   owner_req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Combinational grant in IDLE gives zero added latency; LOCKED freezes the owner.
    always_comb begin
        owner = SEL_CPU;
        if (state == LOCKED)
            owner = lock_owner;
        else if (cpu_req && dma_mem_req)
            owner = (CPU_PRIO || last_served == SEL_DMA) ? SEL_CPU : SEL_DMA;
        else if (dma_mem_req)
            owner = SEL_DMA;
    end

    assign owner_req = (owner == SEL_CPU) ? cpu_req : dma_mem_req;
    assign mem_req   = owner_req && !rst;
    assign mem_we    = (owner == SEL_CPU) ? cpu_we    : dma_mem_we;
    assign mem_addr  = (owner == SEL_CPU) ? cpu_addr  : dma_mem_addr;
    assign mem_wdata = (owner == SEL_CPU) ? cpu_wdata : dma_mem_wdata;

    assign cpu_ready     = mem_req && mem_ready && (owner == SEL_CPU);
    assign dma_mem_ready = mem_req && mem_ready && (owner == SEL_DMA);
    assign cpu_rdata     = mem_rdata;
    assign dma_mem_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lock_owner   <= SEL_CPU;
            last_served  <= SEL_DMA;
            cpu_done_cnt <= '0;
            dma_done_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (owner_req && !mem_ready) begin
                        state      <= LOCKED;
                        lock_owner <= owner;
                    end
                end
                LOCKED: begin
                    // An owner dropping req mid-stall abandons the transaction uncounted.
                    if (mem_ready || !owner_req)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (owner_req && mem_ready) begin
                last_served <= owner;
                if (owner == SEL_CPU)
                    cpu_done_cnt <= sat_inc(cpu_done_cnt);
                else
                    dma_done_cnt <= sat_inc(dma_done_cnt);
            end
        end
    end
endmodule
